// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: PC redirect, per-stage hold and flush.
// Parks redirects that collide with a bus stall and stretches the flush window.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_ex_i,
    input  logic        hold_bus_i,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        hold_pc_o,
    output logic        hold_if_id_o,
    output logic        hold_id_ex_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        busy_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_PEND  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
    localparam bit         MULTI      = (FLUSH_CYCLES > 1);

    state_t      state, state_n;
    logic [31:0] pend_addr, pend_addr_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] stall_cnt;

    logic        jump, hold, flush;
    logic [31:0] addr;

    // Next-state and raw (pre-reset-gating) outputs
    always_comb begin
        state_n     = state;
        pend_addr_n = pend_addr;
        cnt_n       = cnt;
        jump        = 1'b0;
        addr        = 32'd0;
        hold        = 1'b0;
        flush       = 1'b0;
        unique case (state)
            S_RUN: begin
                if (hold_bus_i) begin
                    hold = 1'b1;
                    if (jump_en_i) begin
                        pend_addr_n = jump_addr_i;
                        state_n     = S_PEND;
                    end
                end else if (jump_en_i) begin
                    jump  = 1'b1;
                    addr  = jump_addr_i;
                    flush = 1'b1;
                    if (MULTI) begin
                        cnt_n   = FLUSH_INIT;
                        state_n = S_FLUSH;
                    end
                end else if (hold_ex_i) begin
                    hold = 1'b1;
                end
            end
            S_PEND: begin
                if (hold_bus_i) begin
                    hold = 1'b1;
                end else begin
                    jump  = 1'b1;
                    addr  = pend_addr;
                    flush = 1'b1;
                    if (MULTI) begin
                        cnt_n   = FLUSH_INIT;
                        state_n = S_FLUSH;
                    end else begin
                        state_n = S_RUN;
                    end
                end
            end
            S_FLUSH: begin
                flush = 1'b1;
                if (hold_bus_i) begin
                    hold = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_n = S_RUN;
                    end
                end
            end
            default: begin
                state_n = S_RUN;
            end
        endcase
    end

    // State, parked target and flush counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            pend_addr <= 32'd0;
            cnt       <= 4'd0;
        end else begin
            state     <= state_n;
            pend_addr <= pend_addr_n;
            cnt       <= cnt_n;
        end
    end

    // Saturating count of cycles with the PC frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (hold && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    // Outputs are forced quiet while reset is held
    always_comb begin
        jump_en_o     = jump & ~rst;
        jump_addr_o   = (jump & ~rst) ? addr : 32'd0;
        hold_pc_o     = hold & ~rst;
        hold_if_id_o  = hold & ~rst;
        hold_id_ex_o  = hold & ~rst;
        flush_if_id_o = flush & ~rst;
        flush_id_ex_o = flush & ~rst;
        busy_o        = (state != S_RUN) & ~rst;
        stall_cnt_o   = rst ? 32'd0 : stall_cnt;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the 3-stage core (pc_reg -> if_id -> id_ex -> ex).
- Consumes the EX-stage redirect (jump_en/jump_addr) and hold requests from EX and the instruction bus.
- Drives PC redirect, per-stage hold and flush.
- Adds sequencing the pipe cannot do combinationally: a redirect that collides with a bus stall is parked and replayed; a configurable multi-cycle flush window follows each redirect.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles flush_* stay asserted per redirect (legal 1..15).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- jump_en_i  in  1  redirect request from ex
- jump_addr_i  in  32  redirect target from ex
- hold_ex_i  in  1  ex multi-cycle op busy
- hold_bus_i  in  1  instruction bus not ready
- jump_en_o  out  1  pc_reg load strobe
- jump_addr_o  out  32  pc_reg load value
- hold_pc_o  out  1  freeze pc_reg
- hold_if_id_o  out  1  freeze if_id
- hold_id_ex_o  out  1  freeze id_ex
- flush_if_id_o  out  1  insert NOP into if_id
- flush_id_ex_o  out  1  insert NOP into id_ex
- busy_o  out  1  state != S_RUN
- stall_cnt_o  out  32  cycles with hold_pc_o=1, saturating

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Registered state: state, pend_addr[31:0], cnt[3:0], stall_cnt[31:0]. All other outputs are Mealy-combinational from state and inputs; 0-latency response to inputs.
- Reset values: state=S_RUN, pend_addr=0, cnt=0, stall_cnt_o=0. While rst=1 all outputs are forced to 0.
- Default output values: all 0. jump_addr_o=0 whenever jump_en_o=0. hold_* are always driven together (hold_pc_o=hold_if_id_o=hold_id_ex_o), called "hold".
- Priority in S_RUN: hold_bus_i > jump_en_i > hold_ex_i.
- S_RUN:
  - hold_bus_i=1: hold=1, no flush. If jump_en_i=1 also: pend_addr<=jump_addr_i, next state S_PEND.
  - else jump_en_i=1: jump_en_o=1, jump_addr_o=jump_addr_i, flush_if_id_o=flush_id_ex_o=1. If FLUSH_CYCLES>1: cnt<=FLUSH_CYCLES-1, next state S_FLUSH; else stay in S_RUN.
  - else hold_ex_i=1: hold=1.
- S_PEND:
  - hold_bus_i=1: hold=1; jump_en_i ignored (EX is frozen and re-presents the same branch).
  - hold_bus_i=0: jump_en_o=1, jump_addr_o=pend_addr, both flushes=1. Next state S_FLUSH with cnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else S_RUN.
- S_FLUSH:
  - Both flushes=1 every cycle; jump_en_i and hold_ex_i ignored (EX holds a flushed NOP).
  - hold_bus_i=1: hold=1, cnt frozen.
  - Otherwise cnt decrements; at cnt==1 with no bus hold, next state S_RUN.
- stall_cnt_o increments on every cycle with hold_pc_o=1 and stops at 32'hFFFF_FFFF (no wrap).
- Target addresses pass through unmodified; no alignment check.
- Reset mid-S_PEND or mid-S_FLUSH discards pend_addr and cnt (both cleared to 0); the first post-reset cycle is S_RUN.
- jump_en_o is asserted for exactly one cycle per accepted redirect; a parked redirect is issued exactly once.

Test Plan:
- Reset: drive rst=1 for 3 cycles with jump_en_i=1, hold_bus_i=1 -> all outputs 0, stall_cnt_o=0, busy_o=0.
- Plain redirect, FLUSH_CYCLES=1: jump_en_i=1, jump_addr_i=0x0000_0100 for 1 cycle -> same cycle jump_en_o=1, jump_addr_o=0x100, both flushes=1; next cycle all 0, busy_o=0.
- Collision: hold_bus_i=1 for 3 cycles with jump_en_i=1, jump_addr_i=0x0000_0200 throughout -> hold=1 for 3 cycles, jump_en_o=0; on the cycle hold_bus_i falls, jump_en_o=1, addr=0x200, flushes=1, exactly once; stall_cnt_o=3.
- FLUSH_CYCLES=3: redirect to 0x40, then hold_bus_i=1 on the 2nd cycle -> flushes high for 4 cycles total; hold=1 only in the 2nd; busy_o falls after the 4th.
- EX hold: hold_ex_i=1 for 5 cycles, no jump -> hold=1 for 5 cycles, no flush, stall_cnt_o=5; a concurrent jump_en_i=1 takes priority (jump issued, no hold that cycle).
- Saturation/reset mid-op: force stall_cnt to 0xFFFF_FFFE, hold 3 cycles -> stays 0xFFFF_FFFF; assert rst during S_PEND -> pend_addr discarded, no jump_en_o after release.
